ecpri_rx_ram_writer: RTL and testbench
======================================

Name: ecpri_rx_ram_writer

Overview:
Upstream stage of the eCPRI receive dual-port frame RAM. Accepts a byte stream of eCPRI messages, parses and checks the 4-byte common header, and writes payload bytes into the RAM's write port as a circular buffer. For each good message it emits a descriptor (base address, length, message type) to the downstream reader. The downstream reader returns freed space through a release interface.

Parameters:
DATA_WIDTH, 8, byte width of stream and RAM data
ADDR_WIDTH, 16, RAM address width
RAM_DEPTH, 256, number of RAM locations; circular-buffer size

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_data  in  DATA_WIDTH  stream byte
s_valid  in  1  byte valid
s_sop  in  1  first byte of message (header byte 0)
s_eop  in  1  last byte of message
s_ready  out  1  byte accepted when s_valid && s_ready
ram_address  out  ADDR_WIDTH  RAM write address
ram_data  out  DATA_WIDTH  write data, driven onto RAM data_0 net only while ram_we=1
ram_cs  out  1  RAM chip select
ram_we  out  1  RAM write enable
ram_oe  out  1  tied 0 (port is write-only)
frm_valid  out  1  descriptor valid
frm_ready  in  1  descriptor consumed
frm_base  out  ADDR_WIDTH  address of first payload byte
frm_len  out  16  payload length in bytes
frm_msg_type  out  8  eCPRI message type (header byte 1)
frm_concat  out  1  C bit (header byte 0 bit 0)
rel_valid  in  1  release pulse from reader
rel_len  in  16  bytes freed
free_cnt  out  ADDR_WIDTH+1  free RAM locations
err_cnt  out  16  dropped-message counter, saturating

Behaviour:
- Reset: all outputs 0 except s_ready=1 and free_cnt=RAM_DEPTH. wr_ptr=0. State=IDLE. A reset mid-message discards all state; RAM contents are not cleared.
- Header: byte0[7:4] is the revision and must equal 1; byte0[0] is C. byte1 is the message type. byte2:byte3 is the payload size, big-endian.
- States:
  - IDLE: wait for an accepted byte with s_sop. Capture byte0, latch frame_base=wr_ptr, go HDR. A byte without sop is ignored.
  - HDR: capture bytes 1..3. After byte3 go PAY. eop in HDR is a runt: go to error handling.
  - PAY: each accepted byte is written to RAM. At eop, check that the byte count equals the payload size and the revision is 1. Pass goes to DESC; fail goes to error handling.
  - DESC: frm_valid=1 with fields stable and s_ready=0. Return to IDLE on the cycle frm_valid && frm_ready.
  - DROP: consume bytes until eop, then go IDLE.
- Header with size 0 and eop on byte3: go straight to DESC with frm_len=0.
- s_ready=0 only in DESC; it is 1 in every other state.
- RAM write timing:
  - Registered: byte accepted in cycle N produces ram_cs=ram_we=1, ram_address=wr_ptr, ram_data=byte in cycle N+1. Otherwise cs=we=0.
  - wr_ptr increments per write and wraps RAM_DEPTH-1 -> 0.
- Free count:
  - Decrements by 1 per write.
  - Increments by rel_len on rel_valid.
  - A write and a release in the same cycle apply net.
- Overflow: a payload byte arriving while free_cnt=0 is not written and is an error.
- Error handling (bad revision, length mismatch, runt, overflow):
  - Restore wr_ptr to frame_base and add back the bytes written for this frame to free_cnt.
  - Increment err_cnt, saturating at 0xFFFF. No descriptor is emitted.
  - Go IDLE if the error byte carried eop, else DROP.
- sop in HDR or PAY: abort the current frame as an error (rewind, err_cnt+1), then start a new frame with this byte (state HDR).
- Descriptor hold: while in DESC, descriptor fields do not change.

Test Plan:
- Good frame 0x10,0x00,0x00,0x04,A1,A2,A3,A4 from reset -> RAM writes to addr 0..3 of A1..A4. frm_valid with base=0, len=4, type=0x00, concat=0. free_cnt=252.
- Revision 2 (byte0=0x20), size 4, 4 payload bytes -> no frm_valid, err_cnt=1, wr_ptr and free_cnt restored (next good frame base=0).
- Size 0x0005 but eop on 3rd payload byte -> err_cnt+1, free_cnt restored. Next frame base equals the old base.
- wr_ptr=254, 4-byte payload with release keeping space -> writes at 254, 255, 0, 1. frm_base=254.
- frm_ready held 0 for 10 cycles in DESC -> s_ready=0, descriptor stable; accepted on first frm_ready=1, then s_ready=1.
- Fill until free_cnt=0, then send a 2-byte frame -> overflow, err_cnt+1. Pulse rel_len=4 -> free_cnt=4. Resend -> success.

Source files
------------

// File: rtl/ecpri_rx_ram_writer.sv
// eCPRI receive front end: parses the 4-byte common header, writes payload bytes into a
// circular RAM buffer and hands one descriptor per good message to the reader.
module ecpri_rx_ram_writer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int RAM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  input  logic                  s_sop,
  input  logic                  s_eop,
  output logic                  s_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [ADDR_WIDTH-1:0] frm_base,
  output logic [15:0]           frm_len,
  output logic [7:0]            frm_msg_type,
  output logic                  frm_concat,
  input  logic                  rel_valid,
  input  logic [15:0]           rel_len,
  output logic [ADDR_WIDTH:0]   free_cnt,
  output logic [15:0]           err_cnt
);

  localparam int FW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, HDR, PAY, DESC, DROP} state_t;

  typedef struct packed {
    logic [3:0]  rev;
    logic        concat;
    logic [7:0]  msg_type;
    logic [15:0] size;
  } hdr_t;

  state_t                  state;
  hdr_t                    hdr;
  logic [1:0]              hdr_idx;
  logic [15:0]             pay_cnt;
  logic [ADDR_WIDTH-1:0]   wr_ptr;
  logic [ADDR_WIDTH-1:0]   frame_base;
  logic [DATA_WIDTH-1:0]   ram_data_q;

  logic                    acc;
  logic                    start;
  logic                    wr_en;
  logic                    err_ev;
  logic                    size0_ok;
  logic                    pay_ok;
  logic [ADDR_WIDTH-1:0]   wr_ptr_inc;
  logic [FW-1:0]           free_nxt;

  assign ram_oe   = 1'b0;
  assign ram_data = ram_we ? ram_data_q : '0;

  always_comb begin
    acc        = s_valid && s_ready;
    start      = acc && s_sop && (state == IDLE || state == HDR || state == PAY);
    wr_en      = acc && (state == PAY) && !s_sop && (free_cnt != '0);
    size0_ok   = (hdr_idx == 2'd3) && ({hdr.size[15:8], s_data[7:0]} == 16'd0) && (hdr.rev == 4'd1);
    pay_ok     = (pay_cnt + 16'd1 == hdr.size) && (hdr.rev == 4'd1);
    wr_ptr_inc = (wr_ptr == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    err_ev     = 1'b0;
    if (acc) begin
      case (state)
        IDLE:    err_ev = s_sop && s_eop;
        HDR:     err_ev = s_sop || (s_eop && !size0_ok);
        PAY:     err_ev = s_sop || (free_cnt == '0) || (s_eop && !pay_ok);
        default: err_ev = 1'b0;
      endcase
    end
    // On abort every byte written for this frame, including one written this cycle, goes back.
    free_nxt = free_cnt
             + (rel_valid ? FW'(rel_len) : '0)
             - FW'(wr_en)
             + (err_ev ? FW'(pay_cnt) + FW'(wr_en) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hdr          <= '0;
      hdr_idx      <= '0;
      pay_cnt      <= '0;
      wr_ptr       <= '0;
      frame_base   <= '0;
      free_cnt     <= FW'(RAM_DEPTH);
      err_cnt      <= '0;
      s_ready      <= 1'b1;
      ram_cs       <= 1'b0;
      ram_we       <= 1'b0;
      ram_address  <= '0;
      ram_data_q   <= '0;
      frm_valid    <= 1'b0;
      frm_base     <= '0;
      frm_len      <= '0;
      frm_msg_type <= '0;
      frm_concat   <= 1'b0;
    end else begin
      free_cnt <= free_nxt;
      ram_cs   <= wr_en;
      ram_we   <= wr_en;
      if (wr_en) begin
        ram_address <= wr_ptr;
        ram_data_q  <= s_data;
      end

      if (err_ev) begin
        wr_ptr <= frame_base;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr_inc;
      end

      if (wr_en) pay_cnt <= pay_cnt + 16'd1;

      if (start) begin
        hdr.rev    <= s_data[7:4];
        hdr.concat <= s_data[0];
        hdr_idx    <= 2'd1;
        pay_cnt    <= '0;
        // An aborted frame has already rewound, so its base is reused.
        if (state == IDLE) frame_base <= wr_ptr;
      end

      case (state)
        IDLE: begin
          if (start && !s_eop) state <= HDR;
        end
        HDR: begin
          if (acc && !s_sop) begin
            hdr_idx <= hdr_idx + 2'd1;
            case (hdr_idx)
              2'd1:    hdr.msg_type   <= s_data[7:0];
              2'd2:    hdr.size[15:8] <= s_data[7:0];
              default: hdr.size[7:0]  <= s_data[7:0];
            endcase
            if (s_eop) begin
              if (size0_ok) begin
                state        <= DESC;
                s_ready      <= 1'b0;
                frm_valid    <= 1'b1;
                frm_base     <= frame_base;
                frm_len      <= '0;
                frm_msg_type <= hdr.msg_type;
                frm_concat   <= hdr.concat;
              end else begin
                state <= IDLE;
              end
            end else if (hdr_idx == 2'd3) begin
              state <= PAY;
            end
          end
        end
        PAY: begin
          if (acc && s_sop) begin
            state <= HDR;
          end else if (acc && free_cnt == '0) begin
            state <= s_eop ? IDLE : DROP;
          end else if (acc && s_eop) begin
            if (pay_ok) begin
              state        <= DESC;
              s_ready      <= 1'b0;
              frm_valid    <= 1'b1;
              frm_base     <= frame_base;
              frm_len      <= hdr.size;
              frm_msg_type <= hdr.msg_type;
              frm_concat   <= hdr.concat;
            end else begin
              state <= IDLE;
            end
          end
        end
        DESC: begin
          if (frm_ready) begin
            state     <= IDLE;
            s_ready   <= 1'b1;
            frm_valid <= 1'b0;
          end
        end
        DROP: begin
          if (acc && s_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecpri_rx_ram_writer.sv
// Directed bench: stimulus pushes expected RAM writes and descriptors into queues,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ecpri_rx_ram_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0, s_sop = 1'b0, s_eop = 1'b0;
  logic        s_ready;
  logic [15:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_cs, ram_we, ram_oe;
  logic        frm_valid;
  logic        frm_ready = 1'b1;
  logic [15:0] frm_base, frm_len;
  logic [7:0]  frm_msg_type;
  logic        frm_concat;
  logic        rel_valid = 1'b0;
  logic [15:0] rel_len = '0;
  logic [16:0] free_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  logic [23:0] exp_wr[$];
  logic [40:0] exp_desc[$];
  logic [23:0] wr_e;
  logic [40:0] desc_e;

  always #5 clk = ~clk;

  ecpri_rx_ram_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RAM_DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
    .ram_address(ram_address), .ram_data(ram_data), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_base(frm_base), .frm_len(frm_len),
    .frm_msg_type(frm_msg_type), .frm_concat(frm_concat),
    .rel_valid(rel_valid), .rel_len(rel_len), .free_cnt(free_cnt), .err_cnt(err_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_we) begin
        if (exp_wr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr %h data %h", ram_address, ram_data);
        end else begin
          wr_e = exp_wr.pop_front();
          chk("ram_write", {ram_cs, ram_oe, ram_address, ram_data}, {1'b1, 1'b0, wr_e});
        end
      end
      if (frm_valid && frm_ready) begin
        if (exp_desc.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_desc: base %h len %h", frm_base, frm_len);
        end else begin
          desc_e = exp_desc.pop_front();
          chk("descriptor", {frm_base, frm_len, frm_msg_type, frm_concat}, desc_e);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sop, input logic eop);
    int n = 0;
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL s_ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] typ, input logic [15:0] size,
                            input int npay, input logic [7:0] d0);
    send_byte(b0, 1'b1, 1'b0);
    send_byte(typ, 1'b0, 1'b0);
    send_byte(size[15:8], 1'b0, 1'b0);
    send_byte(size[7:0], 1'b0, npay == 0);
    for (int i = 0; i < npay; i++) send_byte(d0 + 8'(i), 1'b0, i == npay - 1);
  endtask

  task automatic push_writes(input int base, input int n, input logic [7:0] d0);
    for (int i = 0; i < n; i++) exp_wr.push_back({16'((base + i) % 256), d0 + 8'(i)});
  endtask

  task automatic push_desc(input logic [15:0] base, input logic [15:0] len, input logic [7:0] typ,
                           input logic c);
    exp_desc.push_back({base, len, typ, c});
  endtask

  task automatic release_bytes(input logic [15:0] n);
    rel_valid = 1'b1; rel_len = n;
    @(posedge clk); #1;
    rel_valid = 1'b0; rel_len = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle(3);
    chk("reset_s_ready", s_ready, 1);
    chk("reset_free_cnt", free_cnt, 256);
    chk("reset_frm_valid", frm_valid, 0);
    chk("reset_ram_we", {ram_cs, ram_we, ram_oe}, 0);
    chk("reset_err_cnt", err_cnt, 0);
    rst_n = 1'b1;
    idle(2);

    // good frame from reset
    push_writes(0, 4, 8'hA1); push_desc(0, 4, 8'h00, 0);
    send_frame(8'h10, 8'h00, 16'd4, 4, 8'hA1);
    idle(2);
    chk("good_free_cnt", free_cnt, 252);
    chk("good_err_cnt", err_cnt, 0);
    release_bytes(4);
    chk("release_free_cnt", free_cnt, 256);

    // bad revision: payload written then rewound
    push_writes(4, 4, 8'hA1);
    send_frame(8'h20, 8'h00, 16'd4, 4, 8'hA1);
    idle(2);
    chk("badrev_err_cnt", err_cnt, 1);
    chk("badrev_free_cnt", free_cnt, 256);

    // length mismatch
    push_writes(4, 3, 8'hB0);
    send_frame(8'h10, 8'h00, 16'd5, 3, 8'hB0);
    idle(2);
    chk("badlen_err_cnt", err_cnt, 2);
    chk("badlen_free_cnt", free_cnt, 256);

    // next good frame reuses old base
    push_writes(4, 2, 8'hC0); push_desc(4, 2, 8'h01, 0);
    send_frame(8'h10, 8'h01, 16'd2, 2, 8'hC0);
    idle(2);
    chk("rewind_free_cnt", free_cnt, 254);

    // advance wr_ptr to 254
    push_writes(6, 248, 8'h00); push_desc(6, 248, 8'h03, 0);
    send_frame(8'h10, 8'h03, 16'd248, 248, 8'h00);
    idle(2);
    chk("bulk_free_cnt", free_cnt, 6);
    release_bytes(250);
    chk("bulk_release", free_cnt, 256);

    // wrap with a release landing mid-payload
    push_writes(254, 4, 8'hD0); push_desc(254, 4, 8'h04, 0);
    fork
      send_frame(8'h10, 8'h04, 16'd4, 4, 8'hD0);
      begin
        repeat (5) @(posedge clk);
        #1; rel_valid = 1'b1; rel_len = 16'd4;
        @(posedge clk); #1; rel_valid = 1'b0; rel_len = '0;
      end
    join
    idle(2);
    chk("wrap_free_cnt", free_cnt, 256);

    // descriptor held while frm_ready is low
    frm_ready = 1'b0;
    push_writes(2, 1, 8'h55); push_desc(2, 1, 8'h02, 1);
    send_frame(8'h11, 8'h02, 16'd1, 1, 8'h55);
    n = 0;
    while (!frm_valid && n < 20) begin idle(1); n++; end
    chk("hold_frm_valid_seen", frm_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_s_ready", s_ready, 0);
      chk("hold_fields", {frm_valid, frm_base, frm_len, frm_msg_type, frm_concat},
          {1'b1, 16'd2, 16'd1, 8'h02, 1'b1});
      idle(1);
    end
    frm_ready = 1'b1;
    idle(1);
    chk("hold_release_valid", frm_valid, 0);
    chk("hold_release_ready", s_ready, 1);
    chk("hold_free_cnt", free_cnt, 255);

    // fill buffer completely, then overflow
    push_writes(3, 255, 8'h20); push_desc(3, 255, 8'h05, 0);
    send_frame(8'h10, 8'h05, 16'd255, 255, 8'h20);
    idle(2);
    chk("fill_free_cnt", free_cnt, 0);
    send_frame(8'h10, 8'h06, 16'd2, 2, 8'hE0);
    idle(2);
    chk("ovf_err_cnt", err_cnt, 3);
    chk("ovf_free_cnt", free_cnt, 0);
    release_bytes(4);
    chk("ovf_release", free_cnt, 4);
    push_writes(2, 2, 8'hE0); push_desc(2, 2, 8'h06, 0);
    send_frame(8'h10, 8'h06, 16'd2, 2, 8'hE0);
    idle(2);
    chk("resend_free_cnt", free_cnt, 2);
    chk("resend_err_cnt", err_cnt, 3);

    // zero-size message ends on header byte 3
    push_desc(4, 0, 8'h07, 0);
    send_frame(8'h10, 8'h07, 16'd0, 0, 8'h00);
    idle(2);
    chk("size0_free_cnt", free_cnt, 2);

    // runt
    send_byte(8'h10, 1'b1, 1'b0);
    send_byte(8'h00, 1'b0, 1'b1);
    idle(2);
    chk("runt_err_cnt", err_cnt, 4);

    // sop mid-payload aborts and restarts at same base
    push_writes(4, 2, 8'hF0);
    send_byte(8'h10, 1'b1, 1'b0); send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0); send_byte(8'h04, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0); send_byte(8'hF1, 1'b0, 1'b0);
    push_writes(4, 1, 8'h77); push_desc(4, 1, 8'h08, 0);
    send_frame(8'h10, 8'h08, 16'd1, 1, 8'h77);
    idle(2);
    chk("abort_err_cnt", err_cnt, 5);
    chk("abort_free_cnt", free_cnt, 1);

    idle(5);
    chk("writes_drained", exp_wr.size(), 0);
    chk("descs_drained", exp_desc.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
